seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 63 ++++++
 rtl/seven_seg_scanner_if.sv | 34 +++
 rtl/seven_seg_scanner.sv | 140 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scanner.
//   state_t     : scan FSM states (IDLE, BLANK, SHOW)
//   ANODE_*     : active-low anode codes, one low bit per digit position
//   next_t      : result of next_digit (next index + frame-wrap flag)
//   first_digit : lowest enabled position of a digit mask
//   next_digit  : next higher enabled position, wrapping to the lowest
//   anode_for   : anode code that lights a given position
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [3:0] ANODE_D0  = 4'b1110;
  localparam logic [3:0] ANODE_D1  = 4'b1101;
  localparam logic [3:0] ANODE_D2  = 4'b1011;
  localparam logic [3:0] ANODE_D3  = 4'b0111;

  typedef struct packed {
    logic [1:0] idx;
    logic       wrap;
  } next_t;

  // Returns 0 for an empty mask; the FSM never leaves IDLE in that case.
  function automatic logic [1:0] first_digit(input logic [3:0] mask);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Scanning downwards leaves the lowest enabled position above idx in r.idx.
  // If none exists, the scan wraps to the lowest enabled position.
  function automatic next_t next_digit(input logic [1:0] idx, input logic [3:0] mask);
    next_t r;
    r.idx  = first_digit(mask);
    r.wrap = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(idx)) && mask[i]) begin
        r.idx  = 2'(i);
        r.wrap = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] a;
    case (idx)
      2'd0:    a = ANODE_D0;
      2'd1:    a = ANODE_D1;
      2'd2:    a = ANODE_D2;
      default: a = ANODE_D3;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Bus between the scanner and its environment (clock and reset stay outside).
//   enable, load, opCodeIn, lowerIn, upperIn : control and new digit values
//   anode, opCode, lowerBits, upperBits      : display drive and shadow values
//   frameDone                                : one-cycle pulse at each frame wrap
//   dbg_state                                : current scan FSM state
//
// Handshake: load is a single-cycle strobe sampled on every rising clock
// edge; there is no ready signal because the scanner accepts a load on any
// cycle (a later load simply overwrites an earlier pending one).
interface seven_seg_scanner_if;
  import seven_seg_pkg::*;

  logic       enable;
  logic       load;
  logic [3:0] opCodeIn;
  logic [3:0] lowerIn;
  logic [3:0] upperIn;
  logic [3:0] anode;
  logic [3:0] opCode;
  logic [3:0] lowerBits;
  logic [3:0] upperBits;
  logic       frameDone;
  state_t     dbg_state;

  modport master (
    output enable, load, opCodeIn, lowerIn, upperIn,
    input  anode, opCode, lowerBits, upperBits, frameDone, dbg_state
  );

  modport slave (
    input  enable, load, opCodeIn, lowerIn, upperIn,
    output anode, opCode, lowerBits, upperBits, frameDone, dbg_state
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexing driver for a 4-digit seven-segment display.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : seven_seg_scanner_if.slave (controls, anode, shadow values,
//                frameDone, debug state)
// Each digit slot lasts DIV = CLK_HZ/DIGIT_HZ cycles: BLANK_CYCLES with all
// anodes off, then the rest with one anode low. Shadow values only change at
// frame boundaries so the decoder never shows a half-updated frame.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int         CLK_HZ       = 100_000_000,
  parameter int         DIGIT_HZ     = 1000,
  parameter int         BLANK_CYCLES = 16,
  parameter logic [3:0] DIGIT_MASK   = 4'b1101
) (
  input  logic                clk,
  input  logic                rst_n,
  seven_seg_scanner_if.slave  bus
);

  localparam int DIV = CLK_HZ / DIGIT_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - BLANK_CYCLES - 1);
  localparam logic [1:0]    FIRST_IDX  = first_digit(DIGIT_MASK);

  if ((BLANK_CYCLES < 1) || (BLANK_CYCLES >= DIV)) begin : g_cfg_check
    $error("seven_seg_scanner: BLANK_CYCLES must be in [1, DIV-1]");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          wrap_evt;
  next_t         nd;

  logic [3:0]    stg_op, stg_lo, stg_up;
  logic          pending;

  // Next-state logic. wrap_evt marks the last SHOW cycle of the highest
  // enabled digit; the registered frameDone therefore rises on the first
  // BLANK cycle of the new frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    wrap_evt = 1'b0;
    nd       = next_digit(idx_q, DIGIT_MASK);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.enable && (DIGIT_MASK != 4'b0000)) begin
          state_d = BLANK;
          idx_d   = FIRST_IDX;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d  = BLANK;
          cnt_d    = '0;
          idx_d    = nd.idx;
          wrap_evt = nd.wrap;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Dropping enable darkens the display on the next cycle from any state.
    if (!bus.enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      idx_d    = FIRST_IDX;
      wrap_evt = 1'b0;
    end
  end

  // FSM, slot counter and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= FIRST_IDX;
      bus.anode     <= ANODE_OFF;
      bus.frameDone <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      bus.anode     <= (state_d == SHOW) ? anode_for(idx_d) : ANODE_OFF;
      bus.frameDone <= wrap_evt;
    end
  end

  // Staging / shadow. A load that lands on the wrap edge, on the frameDone
  // cycle, or while idle goes straight to the shadow; any other load waits
  // in staging until the next wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_op        <= '0;
      stg_lo        <= '0;
      stg_up        <= '0;
      pending       <= 1'b0;
      bus.opCode    <= '0;
      bus.lowerBits <= '0;
      bus.upperBits <= '0;
    end else if (bus.load && (wrap_evt || bus.frameDone || (state_q == IDLE))) begin
      stg_op        <= bus.opCodeIn;
      stg_lo        <= bus.lowerIn;
      stg_up        <= bus.upperIn;
      pending       <= 1'b0;
      bus.opCode    <= bus.opCodeIn;
      bus.lowerBits <= bus.lowerIn;
      bus.upperBits <= bus.upperIn;
    end else if (bus.load) begin
      stg_op  <= bus.opCodeIn;
      stg_lo  <= bus.lowerIn;
      stg_up  <= bus.upperIn;
      pending <= 1'b1;
    end else if (wrap_evt && pending) begin
      pending       <= 1'b0;
      bus.opCode    <= stg_op;
      bus.lowerBits <= stg_lo;
      bus.upperBits <= stg_up;
    end
  end

  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: DIV=16, BLANK_CYCLES=4, three instances with
// digit masks 1101, 0001 and 0000.
module tb_seven_seg_scanner;

  localparam int CLK_HZ   = 64;
  localparam int DIGIT_HZ = 4;
  localparam int BLANK    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [11:0] exp_q[$];
  logic [11:0] sb_exp;

  seven_seg_scanner_if dut_if ();
  seven_seg_scanner_if one_if ();
  seven_seg_scanner_if none_if ();

  seven_seg_scanner #(
    .CLK_HZ(CLK_HZ), .DIGIT_HZ(DIGIT_HZ), .BLANK_CYCLES(BLANK), .DIGIT_MASK(4'b1101)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(dut_if.slave)
  );

  seven_seg_scanner #(
    .CLK_HZ(CLK_HZ), .DIGIT_HZ(DIGIT_HZ), .BLANK_CYCLES(BLANK), .DIGIT_MASK(4'b0001)
  ) u_one (
    .clk(clk), .rst_n(rst_n), .bus(one_if.slave)
  );

  seven_seg_scanner #(
    .CLK_HZ(CLK_HZ), .DIGIT_HZ(DIGIT_HZ), .BLANK_CYCLES(BLANK), .DIGIT_MASK(4'b0000)
  ) u_none (
    .clk(clk), .rst_n(rst_n), .bus(none_if.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] shadow_dut();
    return {dut_if.opCode, dut_if.lowerBits, dut_if.upperBits};
  endfunction

  // Expected anode for mask 1101, k = cycles since the first BLANK cycle (1-based).
  function automatic logic [3:0] exp_anode_main(input int k);
    int p;
    p = (k - 1) % 48;
    if ((p % 16) < BLANK) return 4'b1111;
    case (p / 16)
      0:       return 4'b1110;
      1:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [3:0] exp_anode_one(input int k);
    return (((k - 1) % 16) < BLANK) ? 4'b1111 : 4'b1110;
  endfunction

  // Drive at the falling edge; the next rising edge samples.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [11:0] v);
    dut_if.load = 1'b1;
    {dut_if.opCodeIn, dut_if.lowerIn, dut_if.upperIn} = v;
    tick();
    dut_if.load = 1'b0;
  endtask

  // Queued expectation for a deferred load; a later load replaces it.
  task automatic sb_load(input logic [11:0] v);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(v);
  endtask

  // Runs to the next frameDone cycle, checking the shadow holds meanwhile.
  task automatic wait_frame(input logic [11:0] hold);
    bit seen;
    seen = 1'b0;
    for (int i = 0; (i < 120) && !seen; i++) begin
      tick();
      if (dut_if.frameDone) seen = 1'b1;
      else check("shadow_hold", {20'h0, shadow_dut()}, {20'h0, hold});
    end
    check("frame_seen", {31'h0, seen}, 32'h1);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && dut_if.frameDone && (exp_q.size() > 0)) begin
      sb_exp = exp_q.pop_front();
      check("sb_shadow", {20'h0, shadow_dut()}, {20'h0, sb_exp});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    dut_if.enable = 1'b1;  dut_if.load = 1'b0;
    dut_if.opCodeIn = '0;  dut_if.lowerIn = '0;  dut_if.upperIn = '0;
    one_if.enable = 1'b1;  one_if.load = 1'b0;
    one_if.opCodeIn = '0;  one_if.lowerIn = '0;  one_if.upperIn = '0;
    none_if.enable = 1'b1; none_if.load = 1'b0;
    none_if.opCodeIn = '0; none_if.lowerIn = '0; none_if.upperIn = '0;

    // Reset values
    @(negedge clk);
    check("rst_anode", {28'h0, dut_if.anode}, 32'hF);
    check("rst_frame", {31'h0, dut_if.frameDone}, 32'h0);
    check("rst_shadow", {20'h0, shadow_dut()}, 32'h0);
    check("rst_one_anode", {28'h0, one_if.anode}, 32'hF);
    rst_n = 1'b1;

    // Free-running scan for all three masks
    for (int k = 1; k <= 100; k++) begin
      tick();
      check("scan_anode", {28'h0, dut_if.anode}, {28'h0, exp_anode_main(k)});
      check("scan_frame", {31'h0, dut_if.frameDone},
            {31'h0, (k > 1) && (((k - 1) % 48) == 0)});
      check("one_anode", {28'h0, one_if.anode}, {28'h0, exp_anode_one(k)});
      check("one_frame", {31'h0, one_if.frameDone},
            {31'h0, (k > 1) && (((k - 1) % 16) == 0)});
      check("none_anode", {28'h0, none_if.anode}, 32'hF);
      check("none_frame", {31'h0, none_if.frameDone}, 32'h0);
    end

    // Deferred load
    wait_frame(12'h000);
    repeat (10) tick();
    do_load(12'h3AF);
    sb_load(12'h3AF);
    check("load_mid_hold", {20'h0, shadow_dut()}, 32'h0);
    wait_frame(12'h000);
    check("sb_drained_1", exp_q.size(), 32'h0);

    // Two loads in one frame: last value wins
    repeat (5) tick();
    do_load(12'h123);
    sb_load(12'h123);
    repeat (5) tick();
    do_load(12'h456);
    sb_load(12'h456);
    wait_frame(12'h3AF);
    check("sb_drained_2", exp_q.size(), 32'h0);
    check("last_wins", {20'h0, shadow_dut()}, 32'h456);

    // Load on the frameDone cycle goes straight to the shadow
    do_load(12'h789);
    check("boundary_load", {20'h0, shadow_dut()}, 32'h789);
    wait_frame(12'h789);
    check("boundary_keep", {20'h0, shadow_dut()}, 32'h789);

    // Enable dropped during SHOW of digit 2
    repeat (24) tick();
    check("pre_drop_anode", {28'h0, dut_if.anode}, 32'hB);
    dut_if.enable = 1'b0;
    tick();
    check("drop_anode", {28'h0, dut_if.anode}, 32'hF);
    do_load(12'hABC);
    check("idle_load", {20'h0, shadow_dut()}, 32'hABC);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_anode", {28'h0, dut_if.anode}, 32'hF);
      check("idle_frame", {31'h0, dut_if.frameDone}, 32'h0);
    end
    dut_if.enable = 1'b1;
    for (int i = 0; i < BLANK; i++) begin
      tick();
      check("reen_blank", {28'h0, dut_if.anode}, 32'hF);
    end
    tick();
    check("reen_show", {28'h0, dut_if.anode}, 32'hE);

    // Asynchronous reset mid-SHOW with a pending load
    tick();
    do_load(12'hDE1);
    sb_load(12'hDE1);
    check("pend_hold", {20'h0, shadow_dut()}, 32'hABC);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_anode", {28'h0, dut_if.anode}, 32'hF);
    check("arst_shadow", {20'h0, shadow_dut()}, 32'h0);
    check("arst_frame", {31'h0, dut_if.frameDone}, 32'h0);
    check("arst_one_anode", {28'h0, one_if.anode}, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame(12'h000);
    check("no_stale", {20'h0, shadow_dut()}, 32'h0);
    wait_frame(12'h000);
    check("no_stale_2", {20'h0, shadow_dut()}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
